// File: rtl/secp256k1_jacobian_to_affine.sv
// secp256k1 Jacobian-to-affine conversion: Z^-1 by Fermat inversion, then x = X*Z^-2, y = Y*Z^-3.
// All products share one multi-cycle modular multiplier (start/done pulse handshake).
module secp256k1_mul_mod #(
    parameter logic [255:0] P_MOD = 256'hFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFEFFFFFC2F
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [255:0] a,
    input  logic [255:0] b,
    output logic [255:0] result,
    output logic         done
);
    // p = 2^256 - RED_C, so the high half folds back as hi * RED_C
    localparam logic [256:0] RED_FULL = {1'b1, 256'b0} - {1'b0, P_MOD};
    localparam logic [32:0]  RED_C    = RED_FULL[32:0];

    typedef enum logic [1:0] {MulIdle, MulAcc, MulFold, MulFinal} mul_state_e;

    mul_state_e   state;
    logic [1:0]   digit;
    logic [511:0] prod;
    logic [289:0] fold;
    logic [319:0] partial;
    logic [511:0] partial_sh;
    logic [288:0] hi_c;
    logic [66:0]  top_c;
    logic [256:0] r2;
    logic [255:0] r3;
    logic [255:0] r4;

    // a and b are held stable by the caller from start until done
    always_comb begin
        partial    = {64'b0, a} * {256'b0, b[{digit, 6'd0} +: 64]};
        partial_sh = {192'b0, partial} << {digit, 6'd0};
        hi_c       = {33'b0, prod[511:256]} * {256'b0, RED_C};
        top_c      = {33'b0, fold[289:256]} * {34'b0, RED_C};
        r2         = {1'b0, fold[255:0]} + {190'b0, top_c};
        // r2[256] set implies r2[255:0] is tiny, so this add cannot overflow
        r3         = r2[255:0] + (r2[256] ? {223'b0, RED_C} : 256'b0);
        r4         = (r3 >= P_MOD) ? (r3 - P_MOD) : r3;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= MulIdle;
            digit  <= 2'd0;
            prod   <= '0;
            fold   <= '0;
            result <= '0;
            done   <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                MulIdle: begin
                    if (start) begin
                        prod  <= '0;
                        digit <= 2'd0;
                        state <= MulAcc;
                    end
                end
                MulAcc: begin
                    prod  <= prod + partial_sh;
                    digit <= digit + 2'd1;
                    if (digit == 2'd3) state <= MulFold;
                end
                MulFold: begin
                    fold  <= {34'b0, prod[255:0]} + {1'b0, hi_c};
                    state <= MulFinal;
                end
                MulFinal: begin
                    result <= r4;
                    done   <= 1'b1;
                    state  <= MulIdle;
                end
                default: state <= MulIdle;
            endcase
        end
    end
endmodule

module secp256k1_jacobian_to_affine #(
    parameter logic [255:0] P_MOD   = 256'hFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFEFFFFFC2F,
    parameter logic [255:0] INV_EXP = P_MOD - 256'd2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [255:0] x_in,
    input  logic [255:0] y_in,
    input  logic [255:0] z_in,
    output logic [255:0] x_out,
    output logic [255:0] y_out,
    output logic         inf_out,
    output logic         busy,
    output logic         done
);
    typedef enum logic [3:0] {
        StIdle, StCheck, StInvSqr, StInvMul, StZi2, StZi3, StXAff, StYAff, StDone
    } state_e;

    state_e       state;
    logic [255:0] xr, yr, zr, acc, zi2;
    logic [255:0] mul_a, mul_b, mul_res;
    logic [7:0]   bit_idx;
    logic         mul_start, mul_done;

    secp256k1_mul_mod #(
        .P_MOD (P_MOD)
    ) u_mul (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (mul_start),
        .a      (mul_a),
        .b      (mul_b),
        .result (mul_res),
        .done   (mul_done)
    );

    // Each state consumes mul_res on mul_done and issues the next product in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= StIdle;
            xr        <= '0;
            yr        <= '0;
            zr        <= '0;
            acc       <= '0;
            zi2       <= '0;
            mul_a     <= '0;
            mul_b     <= '0;
            mul_start <= 1'b0;
            bit_idx   <= 8'd254;
            x_out     <= '0;
            y_out     <= '0;
            inf_out   <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            mul_start <= 1'b0;
            done      <= 1'b0;
            case (state)
                StIdle: begin
                    if (start) begin
                        xr    <= x_in;
                        yr    <= y_in;
                        zr    <= z_in;
                        busy  <= 1'b1;
                        state <= StCheck;
                    end
                end
                StCheck: begin
                    if (zr == '0) begin
                        x_out   <= '0;
                        y_out   <= '0;
                        inf_out <= 1'b1;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        state   <= StDone;
                    end else begin
                        // exponent MSB is 1, so acc starts at Z and the loop begins at bit 254
                        acc       <= zr;
                        bit_idx   <= 8'd254;
                        inf_out   <= 1'b0;
                        mul_a     <= zr;
                        mul_b     <= zr;
                        mul_start <= 1'b1;
                        state     <= StInvSqr;
                    end
                end
                StInvSqr: begin
                    if (mul_done) begin
                        acc       <= mul_res;
                        mul_a     <= mul_res;
                        mul_start <= 1'b1;
                        if (INV_EXP[bit_idx]) begin
                            mul_b <= zr;
                            state <= StInvMul;
                        end else begin
                            mul_b <= mul_res;
                            if (bit_idx == 8'd0) state <= StZi2;
                            else bit_idx <= bit_idx - 8'd1;
                        end
                    end
                end
                StInvMul: begin
                    if (mul_done) begin
                        acc       <= mul_res;
                        mul_a     <= mul_res;
                        mul_b     <= mul_res;
                        mul_start <= 1'b1;
                        if (bit_idx == 8'd0) begin
                            state <= StZi2;
                        end else begin
                            bit_idx <= bit_idx - 8'd1;
                            state   <= StInvSqr;
                        end
                    end
                end
                StZi2: begin
                    if (mul_done) begin
                        zi2       <= mul_res;
                        mul_a     <= mul_res;
                        mul_b     <= acc;
                        mul_start <= 1'b1;
                        state     <= StZi3;
                    end
                end
                StZi3: begin
                    // acc is free after this point; it now holds Z^-3
                    if (mul_done) begin
                        acc       <= mul_res;
                        mul_a     <= xr;
                        mul_b     <= zi2;
                        mul_start <= 1'b1;
                        state     <= StXAff;
                    end
                end
                StXAff: begin
                    if (mul_done) begin
                        x_out     <= mul_res;
                        mul_a     <= yr;
                        mul_b     <= acc;
                        mul_start <= 1'b1;
                        state     <= StYAff;
                    end
                end
                StYAff: begin
                    if (mul_done) begin
                        y_out <= mul_res;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= StDone;
                    end
                end
                StDone:  state <= StIdle;
                default: state <= StIdle;
            endcase
        end
    end
endmodule

// File: tb/tb_secp256k1_jacobian_to_affine.sv
// Directed bench for secp256k1_jacobian_to_affine: scoreboard queue filled at issue,
// drained by a monitor branch whenever done is seen.
module tb_secp256k1_jacobian_to_affine;
    localparam logic [255:0] P  = 256'hFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFEFFFFFC2F;
    localparam logic [255:0] GX = 256'h79BE667EF9DCBBAC55A06295CE870B07029BFCDB2DCE28D959F2815B16F81798;
    localparam logic [255:0] GY = 256'h483ADA7726A3C4655DA4FBFC0E1108A8FD17B448A68554199C47D08FFB10D4B8;
    localparam int MUL_OPS = 507;
    localparam int TIMEOUT = 20000;

    typedef struct {
        logic [255:0] x;
        logic [255:0] y;
        logic         inf;
    } exp_t;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [255:0] x_in, y_in, z_in;
    logic [255:0] x_out, y_out;
    logic         inf_out, busy, done;

    int   checks;
    int   errors;
    int   mul_cnt;
    logic done_prev;
    exp_t exp_q[$];

    secp256k1_jacobian_to_affine dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .x_in    (x_in),
        .y_in    (y_in),
        .z_in    (z_in),
        .x_out   (x_out),
        .y_out   (y_out),
        .inf_out (inf_out),
        .busy    (busy),
        .done    (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [255:0] add_mod(input logic [255:0] a, input logic [255:0] b);
        logic [256:0] s;
        s = {1'b0, a} + {1'b0, b};
        if (s >= {1'b0, P}) s = s - {1'b0, P};
        return s[255:0];
    endfunction

    function automatic logic [255:0] scale(input logic [255:0] a, input int k);
        logic [255:0] r;
        r = '0;
        for (int i = 0; i < k; i++) r = add_mod(r, a);
        return r;
    endfunction

    task automatic chk(input string name, input logic [255:0] got, input logic [255:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, want);
        end
    endtask

    // Issues one conversion and waits for done; the start cycle counts as cycle 1.
    task automatic run(input string name, input logic [255:0] x, input logic [255:0] y,
                       input logic [255:0] z, input logic [255:0] ex, input logic [255:0] ey,
                       input logic einf, input int exp_muls, input int exp_cycle);
        int cyc;
        int muls0;
        bit seen;
        exp_q.push_back('{x: ex, y: ey, inf: einf});
        @(negedge clk);
        muls0 = mul_cnt;
        x_in  = x;
        y_in  = y;
        z_in  = z;
        start = 1'b1;
        cyc   = 1;
        seen  = 1'b0;
        for (int i = 0; i < TIMEOUT && !seen; i++) begin
            @(negedge clk);
            start = 1'b0;
            cyc++;
            if (cyc == 2) chk({name, "_busy_set"}, {255'b0, busy}, 256'd1);
            if (done) seen = 1'b1;
        end
        if (!seen) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: got no done expected done within %0d cycles", name, TIMEOUT);
        end else begin
            chk({name, "_busy_clear"}, {255'b0, busy}, 256'd0);
            chk({name, "_mul_ops"}, 256'(mul_cnt - muls0), 256'(exp_muls));
            if (exp_cycle > 0) chk({name, "_done_cycle"}, 256'(cyc), 256'(exp_cycle));
        end
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        mul_cnt   = 0;
        done_prev = 1'b0;
        rst_n     = 1'b0;
        start     = 1'b0;
        x_in      = '0;
        y_in      = '0;
        z_in      = '0;
        fork
            forever begin
                @(negedge clk);
                if (dut.mul_start) mul_cnt++;
                if (done) begin
                    if (done_prev) begin
                        checks++;
                        errors++;
                        $display("FAIL done_width: got 2+ cycles expected 1");
                    end
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_done: got done expected none");
                    end else begin
                        exp_t e;
                        e = exp_q.pop_front();
                        chk("x_out", x_out, e.x);
                        chk("y_out", y_out, e.y);
                        chk("inf_out", {255'b0, inf_out}, {255'b0, e.inf});
                    end
                end
                done_prev = done;
            end
            begin
                repeat (3) @(negedge clk);
                chk("rst_x_out", x_out, '0);
                chk("rst_y_out", y_out, '0);
                chk("rst_inf", {255'b0, inf_out}, '0);
                chk("rst_busy", {255'b0, busy}, '0);
                chk("rst_done", {255'b0, done}, '0);
                rst_n = 1'b1;
                repeat (2) @(negedge clk);

                run("g_z1", GX, GY, 256'd1, GX, GY, 1'b0, MUL_OPS, 0);
                run("g_z2", scale(GX, 4), scale(GY, 8), 256'd2, GX, GY, 1'b0, MUL_OPS, 0);
                run("g_zneg", GX, P - GY, P - 256'd1, GX, GY, 1'b0, MUL_OPS, 0);
                run("g_z3", scale(GX, 9), scale(GY, 27), 256'd3, GX, GY, 1'b0, MUL_OPS, 0);
                // Z == 0: start, CHECK, then done in the DONE cycle, with no multiplies
                run("z_zero", GX, GY, 256'd0, '0, '0, 1'b1, 0, 3);

                // A second start mid-run is ignored; the result follows the first request.
                exp_q.push_back('{x: GX, y: GY, inf: 1'b0});
                @(negedge clk);
                x_in  = GX;
                y_in  = GY;
                z_in  = 256'd1;
                start = 1'b1;
                @(negedge clk);
                start = 1'b0;
                repeat (200) @(negedge clk);
                x_in  = 256'h1234;
                y_in  = 256'h5678;
                z_in  = 256'd0;
                start = 1'b1;
                @(negedge clk);
                start = 1'b0;
                x_in  = 256'hDEAD;
                begin
                    bit seen;
                    seen = 1'b0;
                    for (int i = 0; i < TIMEOUT && !seen; i++) begin
                        if (done) seen = 1'b1;
                        else @(negedge clk);
                    end
                    chk("overlap_done_seen", {255'b0, seen}, 256'd1);
                end
                // start raised during the DONE cycle must not be accepted
                start = 1'b1;
                @(negedge clk);
                start = 1'b0;
                chk("start_in_done_ignored", {255'b0, busy}, 256'd0);
                repeat (20) @(negedge clk);
                chk("queue_drained", 256'(exp_q.size()), 256'd0);

                // Reset during inversion aborts; nothing is queued for this request.
                x_in  = scale(GX, 4);
                y_in  = scale(GY, 8);
                z_in  = 256'd2;
                start = 1'b1;
                @(negedge clk);
                start = 1'b0;
                repeat (100) @(negedge clk);
                chk("mid_busy", {255'b0, busy}, 256'd1);
                rst_n = 1'b0;
                #2;
                chk("abort_x_out", x_out, '0);
                chk("abort_y_out", y_out, '0);
                chk("abort_busy", {255'b0, busy}, '0);
                chk("abort_done", {255'b0, done}, '0);
                repeat (2) @(negedge clk);
                rst_n = 1'b1;
                repeat (2) @(negedge clk);
                run("after_reset", GX, GY, 256'd1, GX, GY, 1'b0, MUL_OPS, 0);
                repeat (5) @(negedge clk);

                $display("Result: errors=%0d of %0d checks", errors, checks);
                $finish;
            end
        join_any
    end
endmodule
